// File: rtl/fxp_sqrt_host.sv
// Handshake wrapper around an ap_ctrl_hs fixed-point square-root core: one operand in flight,
// result held until consumed. Define FXP_SQRT_HOST_TIMEOUT_EN to add the core watchdog.
module fxp_sqrt_host #(
    parameter int IN_W    = 24,
    parameter int OUT_W   = 28,
    parameter int TIMEOUT = 255
) (
    input  logic             ap_clk,
    input  logic             ap_rst,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [IN_W-1:0]  s_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [OUT_W-1:0] m_data,
    output logic             core_start,
    input  logic             core_done,
    input  logic             core_idle,
    input  logic             core_ready,
    output logic [IN_W-1:0]  core_in_val,
    input  logic [OUT_W-1:0] core_return,
    output logic             busy,
    output logic [15:0]      tx_count,
    output logic             timeout_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        HOLD  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [IN_W-1:0]  in_val_q, in_val_d;
    logic [OUT_W-1:0] m_data_q, m_data_d;
    logic [15:0]      tx_count_q, tx_count_d;
    logic             s_ready_q, s_ready_d;
    logic             core_start_q, core_start_d;
    logic             m_valid_q, m_valid_d;
    logic             busy_q, busy_d;
    logic             wd_expire_s;
    logic             wd_trip_s;
    logic             unused_idle_s;

    // core_idle is status only and never steers the FSM
    assign unused_idle_s = core_idle;

    // Next-state, datapath capture and next values of the registered handshake outputs
    always_comb begin
        state_d    = state_q;
        in_val_d   = in_val_q;
        m_data_d   = m_data_q;
        tx_count_d = tx_count_q;
        wd_trip_s  = 1'b0;
        case (state_q)
            IDLE: begin
                if (s_valid) begin
                    in_val_d = s_data;
                    state_d  = START;
                end else begin
                    state_d = IDLE;
                end
            end
            START: begin
                if (core_ready && core_done) begin
                    m_data_d = core_return;
                    state_d  = HOLD;
                end else if (wd_expire_s) begin
                    wd_trip_s = 1'b1;
                    in_val_d  = '0;
                    state_d   = IDLE;
                end else if (core_ready) begin
                    state_d = WAIT;
                end else begin
                    state_d = START;
                end
            end
            WAIT: begin
                // A done on the expiry cycle still delivers its result
                if (core_done) begin
                    m_data_d = core_return;
                    state_d  = HOLD;
                end else if (wd_expire_s) begin
                    wd_trip_s = 1'b1;
                    in_val_d  = '0;
                    state_d   = IDLE;
                end else begin
                    state_d = WAIT;
                end
            end
            HOLD: begin
                if (m_ready) begin
                    tx_count_d = tx_count_q + 16'd1;
                    state_d    = IDLE;
                end else begin
                    state_d = HOLD;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        s_ready_d    = (state_d == IDLE);
        core_start_d = (state_d == START);
        m_valid_d    = (state_d == HOLD);
        busy_d       = (state_d != IDLE);
    end

    // State, datapath and output registers with synchronous reset
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state_q      <= IDLE;
            in_val_q     <= '0;
            m_data_q     <= '0;
            tx_count_q   <= 16'd0;
            s_ready_q    <= 1'b1;
            core_start_q <= 1'b0;
            m_valid_q    <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            in_val_q     <= in_val_d;
            m_data_q     <= m_data_d;
            tx_count_q   <= tx_count_d;
            s_ready_q    <= s_ready_d;
            core_start_q <= core_start_d;
            m_valid_q    <= m_valid_d;
            busy_q       <= busy_d;
        end
    end

`ifdef FXP_SQRT_HOST_TIMEOUT_EN
    localparam int WD_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

    logic [WD_W-1:0] wdog_q, wdog_d;
    logic            timeout_err_q, timeout_err_d;

    // Expire on the cycle whose increment would reach the limit
    assign wd_expire_s = (({1'b0, wdog_q} + (WD_W + 1)'(1)) >= (WD_W + 1)'(TIMEOUT));

    // Watchdog runs only while the core owns the operand; zero on every START entry
    always_comb begin
        if ((state_q == START) || (state_q == WAIT)) begin
            wdog_d = wdog_q + WD_W'(1);
        end else begin
            wdog_d = '0;
        end
        timeout_err_d = timeout_err_q | wd_trip_s;
    end

    // Watchdog counter and sticky error flag
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            wdog_q        <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            wdog_q        <= wdog_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign timeout_err = timeout_err_q;
`else
    localparam int unused_timeout_lp = TIMEOUT;
    logic unused_trip_s;

    assign wd_expire_s   = 1'b0;
    assign unused_trip_s = wd_trip_s;
    assign timeout_err   = 1'b0;
`endif

    assign s_ready     = s_ready_q;
    assign m_valid     = m_valid_q;
    assign m_data      = m_data_q;
    assign core_start  = core_start_q;
    assign core_in_val = in_val_q;
    assign busy        = busy_q;
    assign tx_count    = tx_count_q;

endmodule

// File: tb/tb_fxp_sqrt_host.sv
// Self-checking bench for fxp_sqrt_host: a behavioural HLS core model with randomized handshake
// delays, plus directed reset, back-pressure, wrap and (FXP_SQRT_HOST_TIMEOUT_EN) watchdog cases.
module tb_fxp_sqrt_host;

    localparam int IN_W  = 24;
    localparam int OUT_W = 28;
    localparam int TMO   = 16;

    logic             ap_clk = 1'b0;
    logic             ap_rst;
    logic             s_valid;
    logic             s_ready;
    logic [IN_W-1:0]  s_data;
    logic             m_valid;
    logic             m_ready;
    logic [OUT_W-1:0] m_data;
    logic             core_start;
    logic             core_done;
    logic             core_idle;
    logic             core_ready;
    logic [IN_W-1:0]  core_in_val;
    logic [OUT_W-1:0] core_return;
    logic             busy;
    logic [15:0]      tx_count;
    logic             timeout_err;

    int          n_vec = 0;
    int          n_bad = 0;
    logic [15:0] exp_count;

    fxp_sqrt_host #(.IN_W(IN_W), .OUT_W(OUT_W), .TIMEOUT(TMO)) dut (
        .ap_clk(ap_clk), .ap_rst(ap_rst),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .core_start(core_start), .core_done(core_done), .core_idle(core_idle),
        .core_ready(core_ready), .core_in_val(core_in_val), .core_return(core_return),
        .busy(busy), .tx_count(tx_count), .timeout_err(timeout_err)
    );

    always #5 ap_clk = ~ap_clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to the next falling edge; core_idle wanders to show it has no effect.
    task automatic step();
        @(negedge ap_clk);
        core_idle = 1'($urandom);
    endtask

    // One complete transaction; the core raises ready after rdy_dly START cycles and done
    // done_dly cycles after that (0 = same cycle); the sink stalls bp cycles.
    task automatic run_txn(input logic [IN_W-1:0] d, input int rdy_dly, input int done_dly,
                           input logic [OUT_W-1:0] ret, input int bp);
        check_val("s_ready_idle", 32'(s_ready), 32'd1);
        s_valid = 1'b1;
        s_data  = d;
        step();
        s_valid = 1'b0;
        s_data  = IN_W'($urandom);
        check_val("start_on_accept", 32'(core_start), 32'd1);
        check_val("in_val_latched", 32'(core_in_val), 32'(d));
        check_val("s_ready_busy", 32'(s_ready), 32'd0);
        for (int i = 0; i < rdy_dly; i++) begin
            step();
            check_val("start_held", 32'(core_start), 32'd1);
        end
        core_ready = 1'b1;
        if (done_dly == 0) begin
            core_done   = 1'b1;
            core_return = ret;
        end
        step();
        core_ready  = 1'b0;
        core_done   = 1'b0;
        core_return = OUT_W'($urandom);
        if (done_dly > 0) begin
            check_val("start_dropped", 32'(core_start), 32'd0);
            check_val("no_valid_wait", 32'(m_valid), 32'd0);
            for (int i = 1; i < done_dly; i++) begin
                step();
                check_val("in_val_stable", 32'(core_in_val), 32'(d));
                check_val("no_valid_wait", 32'(m_valid), 32'd0);
            end
            core_done   = 1'b1;
            core_return = ret;
            step();
            core_done   = 1'b0;
            core_return = OUT_W'($urandom);
        end
        check_val("m_valid_hold", 32'(m_valid), 32'd1);
        check_val("m_data", 32'(m_data), 32'(ret));
        check_val("start_off_hold", 32'(core_start), 32'd0);
        for (int i = 0; i < bp; i++) begin
            step();
            check_val("bp_valid", 32'(m_valid), 32'd1);
            check_val("bp_data", 32'(m_data), 32'(ret));
            check_val("bp_s_ready", 32'(s_ready), 32'd0);
            check_val("bp_no_start", 32'(core_start), 32'd0);
        end
        m_ready = 1'b1;
        step();
        m_ready   = 1'b0;
        exp_count = exp_count + 16'd1;
        check_val("valid_cleared", 32'(m_valid), 32'd0);
        check_val("turnaround_ready", 32'(s_ready), 32'd1);
        check_val("tx_count", 32'(tx_count), 32'(exp_count));
    endtask

    // Accept an operand and let the core take it, leaving the FSM in WAIT.
    task automatic launch_to_wait(input logic [IN_W-1:0] d);
        s_valid = 1'b1;
        s_data  = d;
        step();
        s_valid    = 1'b0;
        core_ready = 1'b1;
        step();
        core_ready = 1'b0;
    endtask

    initial begin
        ap_rst = 1'b1; s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
        core_done = 1'b0; core_idle = 1'b0; core_ready = 1'b0; core_return = '0;
        exp_count = 16'd0;
        repeat (3) step();
        ap_rst = 1'b0;
        step();
        check_val("rst_s_ready", 32'(s_ready), 32'd1);
        check_val("rst_core_start", 32'(core_start), 32'd0);
        check_val("rst_m_valid", 32'(m_valid), 32'd0);
        check_val("rst_m_data", 32'(m_data), 32'd0);
        check_val("rst_core_in_val", 32'(core_in_val), 32'd0);
        check_val("rst_busy", 32'(busy), 32'd0);
        check_val("rst_tx_count", 32'(tx_count), 32'd0);
        check_val("rst_timeout_err", 32'(timeout_err), 32'd0);

        run_txn(24'h010000, 1, 4, 28'h0000100, 0);
        run_txn(24'h000400, 2, 3, 28'h0000020, 10);
        run_txn(24'h123456, 0, 0, 28'h0ABCDEF, 0);

        core_done   = 1'b1;
        core_return = 28'hFFFFFFF;
        step();
        core_done = 1'b0;
        check_val("idle_done_ignored", 32'(m_valid), 32'd0);
        check_val("idle_done_ready", 32'(s_ready), 32'd1);

        for (int k = 0; k < 20; k++) begin
            run_txn(IN_W'($urandom), int'($urandom_range(0, 4)), int'($urandom_range(0, 6)),
                    OUT_W'($urandom), int'($urandom_range(0, 3)));
        end

`ifdef FXP_SQRT_HOST_TIMEOUT_EN
        launch_to_wait(24'h00BEEF);
        repeat (TMO - 2) step();
        core_done   = 1'b1;
        core_return = 28'h0C0FFEE;
        step();
        core_done = 1'b0;
        check_val("limit_done_valid", 32'(m_valid), 32'd1);
        check_val("limit_done_data", 32'(m_data), 32'h0C0FFEE);
        check_val("limit_done_no_err", 32'(timeout_err), 32'd0);
        m_ready = 1'b1;
        step();
        m_ready   = 1'b0;
        exp_count = exp_count + 16'd1;
        check_val("limit_done_count", 32'(tx_count), 32'(exp_count));
`else
        launch_to_wait(24'h00BEEF);
        repeat (300) step();
        check_val("long_wait_busy", 32'(busy), 32'd1);
        check_val("long_wait_no_valid", 32'(m_valid), 32'd0);
        check_val("no_watchdog_err", 32'(timeout_err), 32'd0);
        core_done   = 1'b1;
        core_return = 28'h0C0FFEE;
        step();
        core_done = 1'b0;
        check_val("long_wait_data", 32'(m_data), 32'h0C0FFEE);
        m_ready = 1'b1;
        step();
        m_ready   = 1'b0;
        exp_count = exp_count + 16'd1;
        check_val("long_wait_count", 32'(tx_count), 32'(exp_count));
`endif

        launch_to_wait(24'h0A0A0A);
        step();
        ap_rst = 1'b1;
        step();
        ap_rst    = 1'b0;
        exp_count = 16'd0;
        check_val("rstw_s_ready", 32'(s_ready), 32'd1);
        check_val("rstw_core_start", 32'(core_start), 32'd0);
        check_val("rstw_m_valid", 32'(m_valid), 32'd0);
        check_val("rstw_busy", 32'(busy), 32'd0);
        check_val("rstw_tx_count", 32'(tx_count), 32'd0);
        check_val("rstw_m_data", 32'(m_data), 32'd0);
        check_val("rstw_in_val", 32'(core_in_val), 32'd0);
        core_done   = 1'b1;
        core_return = 28'h5555555;
        step();
        core_done = 1'b0;
        check_val("late_done_ignored", 32'(m_valid), 32'd0);
        check_val("late_done_m_data", 32'(m_data), 32'd0);

        s_valid = 1'b1;
        s_data  = 24'h777777;
        ap_rst  = 1'b1;
        step();
        ap_rst  = 1'b0;
        s_valid = 1'b0;
        check_val("rst_prio_no_start", 32'(core_start), 32'd0);
        check_val("rst_prio_ready", 32'(s_ready), 32'd1);

        run_txn(24'h000100, 0, 1, 28'h0000010, 0);
        force dut.tx_count_q = 16'hFFFF;
        step();
        release dut.tx_count_q;
        step();
        exp_count = 16'hFFFF;
        run_txn(24'h000009, 1, 1, 28'h0000003, 1);
        check_val("wrap_zero", 32'(tx_count), 32'd0);

`ifdef FXP_SQRT_HOST_TIMEOUT_EN
        launch_to_wait(24'h00DEAD);
        repeat (TMO - 2) step();
        check_val("pre_timeout_busy", 32'(busy), 32'd1);
        check_val("pre_timeout_err", 32'(timeout_err), 32'd0);
        step();
        check_val("timeout_err_set", 32'(timeout_err), 32'd1);
        check_val("timeout_idle", 32'(s_ready), 32'd1);
        check_val("timeout_busy", 32'(busy), 32'd0);
        check_val("timeout_no_start", 32'(core_start), 32'd0);
        check_val("timeout_no_valid", 32'(m_valid), 32'd0);
        check_val("timeout_count", 32'(tx_count), 32'(exp_count));
        run_txn(24'h000051, 1, 2, 28'h0000009, 0);
        check_val("timeout_err_sticky", 32'(timeout_err), 32'd1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
